// File: rtl/sram_bank.sv
// Parametrised single-port synchronous SRAM bank: byte enables, valid/ready requests, registered read, post-reset clear sweep.
// Optional per-byte even parity with error injection is enabled by defining SRAM_PARITY_EN.
module sram_bank #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    WE,
  input  logic [DATA_W/8-1:0]     be,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    rd_valid,
  output logic                    init_done
`ifdef SRAM_PARITY_EN
  ,
  input  logic                    err_inject,
  output logic                    par_err
`endif
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;

  logic w_run;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_run    = (r_state == S_RUN);
  assign w_wr_acc = w_run && req_valid && WE;
  assign w_rd_acc = w_run && req_valid && !WE;

  assign req_ready = w_run;
  assign init_done = w_run;
  assign data_out  = r_data_out;
  assign rd_valid  = r_rd_valid;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
      if (r_clr_addr == '1) begin
        r_state <= S_RUN;
      end
    end
  end

  // Array has no reset; the clear sweep is the only initialisation path.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_addr] <= CLEAR_VAL;
    end else if (w_wr_acc) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_out <= r_mem[addr];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NBYTES-1:0] r_par [DEPTH];
  logic [NBYTES-1:0] w_clr_par;
  logic [NBYTES-1:0] w_rd_par;
  logic              r_par_err;

  always_comb begin
    w_clr_par = '0;
    w_rd_par  = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      w_clr_par[i] = ^CLEAR_VAL[8*i +: 8];
      w_rd_par[i]  = ^r_mem[addr][8*i +: 8];
    end
  end

  // Injection flips only the parity of enabled bytes; the data is stored intact.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_par[r_clr_addr] <= w_clr_par;
    end else if (w_wr_acc) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (be[i]) begin
          r_par[addr][i] <= (^data_in[8*i +: 8]) ^ err_inject;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_rd_acc && (|(w_rd_par ^ r_par[addr]));
    end
  end

  assign par_err = r_par_err;
`endif

endmodule

// File: doc/sram_bank.md
Name: sram_bank

Overview:
Parametrised single-port synchronous SRAM bank. It succeeds the fixed 256x32 SRAM and adds generic width and depth, per-byte write enables, a valid/ready request handshake, a registered read with a read-valid strobe, and a hardware clear sweep after reset. It serves as the data/instruction memory bank behind the CPU load/store path.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8; NBYTES = DATA_W/8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
CLEAR_VAL, 0, value written to every word by the post-reset clear sweep (DATA_W bits)

Ports:
clk  input  1  clock; all state changes on the rising edge
res  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  bank accepts requests (high only in RUN)
WE  input  1  1 = write, 0 = read; sampled on an accepted request
be  input  NBYTES  byte enables for writes; be[i] covers data_in[8i+7:8i]
addr  input  ADDR_W  word address
data_in  input  DATA_W  write data
data_out  output  DATA_W  registered read data
rd_valid  output  1  one-cycle strobe: data_out holds new read data
init_done  output  1  clear sweep complete

Behaviour:
- Reset (res=0, asynchronous): state=CLEAR, clr_addr=0, data_out=0, rd_valid=0, req_ready=0, init_done=0. Memory contents are not reset directly.
- CLEAR state: each clock writes CLEAR_VAL to mem[clr_addr], then clr_addr increments. The write at clr_addr==DEPTH-1 moves the FSM to RUN.
  - The sweep takes exactly DEPTH cycles after reset release.
  - In the first cycle of RUN, init_done=1 and req_ready=1; both stay high until the next reset.
- Reset during CLEAR or RUN: the sweep restarts from address 0. Any in-flight read strobe is dropped (rd_valid=0).
- Accept: req_valid && req_ready at a rising edge. When req_ready=0, requests are ignored with no side effects.
- Write accept: for each i with be[i]=1, mem[addr] byte i gets data_in byte i at that edge.
  - Bytes with be[i]=0 are unchanged. be=0 is accepted as a no-op.
  - rd_valid=0 next cycle; data_out holds its value.
- Read accept: data_out is loaded with mem[addr] at the accept edge (latency 1). rd_valid=1 for exactly the following cycle.
  - Back-to-back reads give one result per cycle; rd_valid stays high continuously.
  - data_out holds the last read value until the next read.
- Single port: one access per cycle, so no collision case. A write at cycle N followed by a read of the same address at N+1 returns the new data.
- The addr width exactly spans DEPTH. Address DEPTH-1 and address 0 are distinct words; there is no aliasing or wrap beyond the array.
- X or Z on inputs while req_valid=0 has no effect.

Optional Feature:
SRAM_PARITY_EN
- Defined:
  - Adds one even-parity bit per byte, stored with every write, including clear-sweep writes.
  - Adds input err_inject (1 bit): on an accepted write with err_inject=1, the stored parity bits of enabled bytes are inverted.
  - Adds output par_err (1 bit, reset 0): on a read, registered alongside data_out; high with rd_valid if any byte's recomputed parity mismatches. Cleared to 0 in any cycle without rd_valid.
- Undefined: no parity storage, no err_inject or par_err ports; behaviour otherwise identical.

Test Plan:
1. ADDR_W=8: hold res=0 for 3 cycles, release -> init_done=0 and req_ready=0 for exactly 256 cycles, then 1; read of addr 0x00, 0x80 and 0xFF -> data_out=CLEAR_VAL (0), rd_valid one cycle after each accept.
2. Write 0x05 <= 0xDEADBEEF with be=4'hF, read 0x05 the next cycle -> data_out=0xDEADBEEF with rd_valid=1 for one cycle; back-to-back reads of 0x05 then 0x06 -> 0xDEADBEEF then 0x00000000 on consecutive cycles.
3. After scenario 2, write 0x05 <= 0x11223344 with be=4'b0101, then read -> 0xDE22BE44; write with be=0 -> readback still 0xDE22BE44.
4. Write 0xFF <= 0xA5A5A5A5 and 0x00 <= 0x5A5A5A5A, read both -> each returns its own value; req_valid asserted during CLEAR -> ignored, memory still CLEAR_VAL afterwards.
5. Pull res low at sweep count 100, release -> sweep restarts, init_done rises 256 cycles after the second release; pull res low during a read -> rd_valid=0 and data_out=0 immediately.
6. With SRAM_PARITY_EN: write 0x10 <= 0x0F0F0F0F with err_inject=1 and be=4'b0001, read -> par_err=1 with rd_valid; normal write and read of 0x11 -> par_err=0.
